// File: rtl/traffic_phase_ctrl.sv
// Tick-driven phase sequencer for a two-road intersection with a pedestrian walk phase.
// Moore lamp outputs; a latched pedestrian request diverts the next all-red exit into WALK.
module traffic_phase_ctrl #(
    parameter int unsigned DUR_W    = 8,
    parameter int unsigned T_GREEN  = 10,
    parameter int unsigned T_YELLOW = 3,
    parameter int unsigned T_ALLRED = 1,
    parameter int unsigned T_WALK   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             ped_req,
    output logic [2:0]       ns_light,
    output logic [2:0]       ew_light,
    output logic             walk,
    output logic             ped_ack,
    output logic             ped_pend,
    output logic [DUR_W-1:0] phase_cnt
);

    localparam logic [2:0] RED_A     = 3'd0;
    localparam logic [2:0] NS_GREEN  = 3'd1;
    localparam logic [2:0] NS_YELLOW = 3'd2;
    localparam logic [2:0] RED_B     = 3'd3;
    localparam logic [2:0] EW_GREEN  = 3'd4;
    localparam logic [2:0] EW_YELLOW = 3'd5;
    localparam logic [2:0] WALK      = 3'd6;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    // Terminal count per phase: the tick that sees cnt == T-1 ends the phase.
    localparam logic [DUR_W-1:0] LAST_GREEN  = DUR_W'(T_GREEN - 1);
    localparam logic [DUR_W-1:0] LAST_YELLOW = DUR_W'(T_YELLOW - 1);
    localparam logic [DUR_W-1:0] LAST_ALLRED = DUR_W'(T_ALLRED - 1);
    localparam logic [DUR_W-1:0] LAST_WALK   = DUR_W'(T_WALK - 1);

    logic [2:0]       state_q, state_d;
    logic [DUR_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             pend_q, pend_d;
    logic             ack_q, ack_d;
    logic [DUR_W-1:0] last_cnt;
    logic             phase_done;
    logic             enter_walk;

    always_comb begin
        last_cnt = LAST_ALLRED;
        case (state_q)
            NS_GREEN, EW_GREEN:   last_cnt = LAST_GREEN;
            NS_YELLOW, EW_YELLOW: last_cnt = LAST_YELLOW;
            WALK:                 last_cnt = LAST_WALK;
            default:              last_cnt = LAST_ALLRED;
        endcase
    end

    assign phase_done = tick && (cnt_q == last_cnt);

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        if (tick) begin
            if (phase_done) begin
                cnt_d = '0;
                case (state_q)
                    RED_A: begin
                        if (pend_q) begin
                            state_d = WALK;
                            dir_d   = 1'b0;
                        end else begin
                            state_d = NS_GREEN;
                        end
                    end
                    NS_GREEN:  state_d = NS_YELLOW;
                    NS_YELLOW: state_d = RED_B;
                    RED_B: begin
                        if (pend_q) begin
                            state_d = WALK;
                            dir_d   = 1'b1;
                        end else begin
                            state_d = EW_GREEN;
                        end
                    end
                    EW_GREEN:  state_d = EW_YELLOW;
                    EW_YELLOW: state_d = RED_A;
                    WALK:      state_d = dir_q ? EW_GREEN : NS_GREEN;
                    default:   state_d = RED_A;
                endcase
            end else begin
                cnt_d = cnt_q + DUR_W'(1);
            end
        end
    end

    assign enter_walk = (state_d == WALK) && (state_q != WALK);

    // Requests on the entry edge or while walking are absorbed by the walk being served.
    always_comb begin
        pend_d = pend_q;
        if (enter_walk) begin
            pend_d = 1'b0;
        end else if (ped_req && (state_q != WALK)) begin
            pend_d = 1'b1;
        end
    end

    assign ack_d = enter_walk;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RED_A;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            pend_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        ns_light = LAMP_RED;
        ew_light = LAMP_RED;
        case (state_q)
            NS_GREEN:  ns_light = LAMP_GREEN;
            NS_YELLOW: ns_light = LAMP_YELLOW;
            EW_GREEN:  ew_light = LAMP_GREEN;
            EW_YELLOW: ew_light = LAMP_YELLOW;
            default: begin
                ns_light = LAMP_RED;
                ew_light = LAMP_RED;
            end
        endcase
    end

    assign walk      = (state_q == WALK);
    assign ped_ack   = ack_q;
    assign ped_pend  = pend_q;
    assign phase_cnt = cnt_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl: directed scenarios with literal expectations,
// then randomized ticks/requests/resets, all compared every cycle against a phase-table model.
module tb_traffic_phase_ctrl;

    localparam int unsigned DUR_W    = 4;
    localparam int unsigned T_GREEN  = 5;
    localparam int unsigned T_YELLOW = 2;
    localparam int unsigned T_ALLRED = 1;
    localparam int unsigned T_WALK   = 3;

    localparam int PH_RA  = 0;
    localparam int PH_NSG = 1;
    localparam int PH_NSY = 2;
    localparam int PH_RB  = 3;
    localparam int PH_EWG = 4;
    localparam int PH_EWY = 5;
    localparam int PH_WK  = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             tick = 1'b0;
    logic             ped_req = 1'b0;
    logic [2:0]       ns_light;
    logic [2:0]       ew_light;
    logic             walk;
    logic             ped_ack;
    logic             ped_pend;
    logic [DUR_W-1:0] phase_cnt;

    traffic_phase_ctrl #(
        .DUR_W   (DUR_W),
        .T_GREEN (T_GREEN),
        .T_YELLOW(T_YELLOW),
        .T_ALLRED(T_ALLRED),
        .T_WALK  (T_WALK)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .ped_req  (ped_req),
        .ns_light (ns_light),
        .ew_light (ew_light),
        .walk     (walk),
        .ped_ack  (ped_ack),
        .ped_pend (ped_pend),
        .phase_cnt(phase_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cc    = 0;

    int m_ph   = PH_RA;
    int m_cnt  = 0;
    bit m_dir  = 1'b0;
    bit m_pend = 1'b0;
    bit m_ack  = 1'b0;

    function automatic int ph_dur(input int p);
        case (p)
            PH_NSG, PH_EWG: return T_GREEN;
            PH_NSY, PH_EWY: return T_YELLOW;
            PH_WK:          return T_WALK;
            default:        return T_ALLRED;
        endcase
    endfunction

    function automatic int ns_lamp(input int p);
        if (p == PH_NSG) return 1;
        if (p == PH_NSY) return 2;
        return 4;
    endfunction

    function automatic int ew_lamp(input int p);
        if (p == PH_EWG) return 1;
        if (p == PH_EWY) return 2;
        return 4;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d, t=%0t)", name, act, exp, cc, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit t, input bit q);
        int nxt;
        bit enter;
        if (r) begin
            m_ph = PH_RA; m_cnt = 0; m_dir = 0; m_pend = 0; m_ack = 0;
            return;
        end
        nxt = m_ph;
        enter = 0;
        if (t) begin
            if (m_cnt == ph_dur(m_ph) - 1) begin
                m_cnt = 0;
                case (m_ph)
                    PH_RA:  if (m_pend) begin nxt = PH_WK; m_dir = 0; end else nxt = PH_NSG;
                    PH_NSG: nxt = PH_NSY;
                    PH_NSY: nxt = PH_RB;
                    PH_RB:  if (m_pend) begin nxt = PH_WK; m_dir = 1; end else nxt = PH_EWG;
                    PH_EWG: nxt = PH_EWY;
                    PH_EWY: nxt = PH_RA;
                    default: nxt = m_dir ? PH_EWG : PH_NSG;
                endcase
                enter = (nxt == PH_WK);
            end else begin
                m_cnt++;
            end
        end
        if (enter) m_pend = 0;
        else if (q && m_ph != PH_WK) m_pend = 1;
        m_ack = enter;
        m_ph  = nxt;
    endtask

    task automatic compare_all();
        check("ns_light", int'(ns_light), ns_lamp(m_ph));
        check("ew_light", int'(ew_light), ew_lamp(m_ph));
        check("walk", int'(walk), int'(m_ph == PH_WK));
        check("ped_ack", int'(ped_ack), int'(m_ack));
        check("ped_pend", int'(ped_pend), int'(m_pend));
        check("phase_cnt", int'(phase_cnt), m_cnt);
        check("both_roads_nonred", int'(ns_light != 3'b100 && ew_light != 3'b100), 0);
    endtask

    task automatic cyc(input bit r, input bit q, input bit t);
        rst = r;
        ped_req = q;
        tick = t;
        @(posedge clk);
        model_step(r, t, q);
        #1;
        compare_all();
        cc++;
    endtask

    function automatic bit tick_due();
        return (cc % 4) == 3;
    endfunction

    // mode 0: no request, 1: request every cycle, 2: request only on tick cycles
    task automatic run_ticks(input int n, input int mode);
        int seen = 0;
        while (seen < n) begin
            bit t = tick_due();
            cyc(1'b0, (mode == 1) || (mode == 2 && t), t);
            if (t) seen++;
        end
    endtask

    initial begin
        // Reset and the basic NS/EW progression
        cyc(1'b1, 1'b0, 1'b0);
        check("lit_reset_ns", int'(ns_light), 4);
        check("lit_reset_ew", int'(ew_light), 4);
        check("lit_reset_cnt", int'(phase_cnt), 0);
        run_ticks(1, 0);
        check("lit_ns_green", int'(ns_light), 1);
        run_ticks(5, 0);
        check("lit_ns_yellow", int'(ns_light), 2);
        run_ticks(2, 0);
        check("lit_red_b_ns", int'(ns_light), 4);
        check("lit_red_b_ew", int'(ew_light), 4);
        run_ticks(1, 0);
        check("lit_ew_green", int'(ew_light), 1);

        // One full 16-tick period returns to the same point
        run_ticks(16, 0);
        check("lit_period_ew", int'(ew_light), 1);
        check("lit_period_cnt", int'(phase_cnt), 0);

        // Single-cycle request during NS_GREEN, served at RED_B exit
        run_ticks(8, 0);
        check("lit_nsg_again", int'(ns_light), 1);
        cyc(1'b0, 1'b1, 1'b0);
        check("lit_pend_set", int'(ped_pend), 1);
        run_ticks(8, 0);
        check("lit_walk_on", int'(walk), 1);
        check("lit_ack_on", int'(ped_ack), 1);
        check("lit_pend_clr", int'(ped_pend), 0);
        cyc(1'b0, 1'b0, 1'b0);
        check("lit_ack_pulse", int'(ped_ack), 0);
        run_ticks(3, 0);
        check("lit_walk_to_ew", int'(ew_light), 1);
        check("lit_walk_off", int'(walk), 0);

        // Request held through WALK entry and WALK is absorbed
        cyc(1'b0, 1'b1, 1'b0);
        run_ticks(7, 0);
        run_ticks(1, 1);
        check("lit_walk_from_ra", int'(walk), 1);
        check("lit_pend_absorb_entry", int'(ped_pend), 0);
        run_ticks(3, 1);
        check("lit_walk_to_ns", int'(ns_light), 1);
        check("lit_pend_absorb_walk", int'(ped_pend), 0);
        run_ticks(8, 0);
        check("lit_no_second_walk", int'(ew_light), 1);

        // Request on the RED_A terminal tick waits for RED_B
        run_ticks(7, 0);
        run_ticks(1, 2);
        check("lit_ra_exit_ns", int'(ns_light), 1);
        check("lit_ra_exit_pend", int'(ped_pend), 1);
        run_ticks(8, 0);
        check("lit_walk_after_rb", int'(walk), 1);

        // Reset mid-EW_GREEN on a tick cycle with phase_cnt=3
        run_ticks(6, 0);
        check("lit_ewg_cnt3", int'(phase_cnt), 3);
        while (!tick_due()) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        check("lit_rst_ew", int'(ew_light), 4);
        check("lit_rst_cnt", int'(phase_cnt), 0);
        run_ticks(1, 0);
        check("lit_rst_restart", int'(ns_light), 1);

        // Randomized ticks (including back-to-back), requests and resets
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom % 500) == 0, ($urandom % 15) == 0, ($urandom % 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
